// File: rtl/apb_mac_master.sv
// APB master that multiply-accumulates NUM_PAIRS operand pairs from two strided streams and
// writes the sum back in one transfer. Define APB_MAC_SAT_EN to saturate at 2^PDATA_W-1.
module apb_mac_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned PDATA_W = 32,
  parameter int unsigned OP_W    = 16,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned STRIDE  = 4
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_pairs,
  input  logic [ADDR_W-1:0]         Raddr1,
  input  logic [ADDR_W-1:0]         Raddr2,
  input  logic [ADDR_W-1:0]         Waddr,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [PDATA_W-1:0]        PWDATA,
  input  logic [PDATA_W-1:0]        PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output logic [OP_W-1:0]           operand1,
  output logic [OP_W-1:0]           operand2,
  output logic [2*OP_W+CNT_W-1:0]   result,
  output logic                      busy,
  output logic                      reading_completed,
  output logic                      write_completed,
  output logic                      error
);

  localparam int unsigned ACC_W = 2 * OP_W + CNT_W;
  localparam int unsigned SUM_W = ((ACC_W > PDATA_W) ? ACC_W : PDATA_W) + 1;

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StRd1Setup  = 3'd1;
  localparam logic [2:0] StRd1Access = 3'd2;
  localparam logic [2:0] StRd2Setup  = 3'd3;
  localparam logic [2:0] StRd2Access = 3'd4;
  localparam logic [2:0] StWrSetup   = 3'd5;
  localparam logic [2:0] StWrAccess  = 3'd6;
  localparam logic [2:0] StDone      = 3'd7;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   npairs_q, npairs_d;
  logic [ADDR_W-1:0]  addr_a_q, addr_a_d;
  logic [ADDR_W-1:0]  addr_b_q, addr_b_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [OP_W-1:0]    op1_q, op1_d;
  logic [OP_W-1:0]    op2_q, op2_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               rdc_q, rdc_d;
  logic               wrc_q, wrc_d;
  logic               err_q, err_d;

  logic [OP_W-1:0]    rd_op;
  logic [2*OP_W-1:0]  prod;
  logic [ACC_W-1:0]   acc_next;
  logic [PDATA_W-1:0] wdata;
  logic [CNT_W-1:0]   idx_inc;

  assign rd_op   = PRDATA[OP_W-1:0];
  assign prod    = (2*OP_W)'(op1_q) * (2*OP_W)'(rd_op);
  assign idx_inc = idx_q + CNT_W'(1);

  if (PDATA_W > OP_W) begin : gen_unused_prdata
    logic unused_prdata;
    assign unused_prdata = ^PRDATA[PDATA_W-1:OP_W];
  end

`ifdef APB_MAC_SAT_EN
  localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'({PDATA_W{1'b1}});
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] res_ext;

  always_comb begin
    sum      = SUM_W'(acc_q) + SUM_W'(prod);
    acc_next = (sum > SAT_MAX) ? ACC_W'(SAT_MAX) : sum[ACC_W-1:0];
    res_ext  = SUM_W'(acc_q);
    wdata    = (res_ext > SAT_MAX) ? {PDATA_W{1'b1}} : res_ext[PDATA_W-1:0];
  end
`else
  always_comb begin
    acc_next = acc_q + ACC_W'(prod);
    wdata    = PDATA_W'(acc_q);
  end
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    npairs_d = npairs_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    waddr_d  = waddr_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    acc_d    = acc_q;
    err_d    = err_q;
    rdc_d    = 1'b0;
    wrc_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          npairs_d = num_pairs;
          addr_a_d = Raddr1;
          addr_b_d = Raddr2;
          waddr_d  = Waddr;
          idx_d    = '0;
          acc_d    = '0;
          err_d    = 1'b0;
          state_d  = (num_pairs == '0) ? StWrSetup : StRd1Setup;
        end
      end
      StRd1Setup: state_d = StRd1Access;
      StRd1Access: begin
        if (PREADY) begin
          if (PSLVERR) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            op1_d   = rd_op;
            state_d = StRd2Setup;
          end
        end
      end
      StRd2Setup: state_d = StRd2Access;
      StRd2Access: begin
        if (PREADY) begin
          if (PSLVERR) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            op2_d = rd_op;
            acc_d = acc_next;
            if (idx_inc == npairs_q) begin
              rdc_d   = 1'b1;
              state_d = StWrSetup;
            end else begin
              idx_d    = idx_inc;
              addr_a_d = addr_a_q + ADDR_W'(STRIDE);
              addr_b_d = addr_b_q + ADDR_W'(STRIDE);
              state_d  = StRd1Setup;
            end
          end
        end
      end
      StWrSetup: state_d = StWrAccess;
      StWrAccess: begin
        if (PREADY) begin
          if (PSLVERR) err_d = 1'b1;
          else         wrc_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      npairs_q <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      waddr_q  <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      acc_q    <= '0;
      rdc_q    <= 1'b0;
      wrc_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      npairs_q <= npairs_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      waddr_q  <= waddr_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      acc_q    <= acc_d;
      rdc_q    <= rdc_d;
      wrc_q    <= wrc_d;
      err_q    <= err_d;
    end
  end

  // Bus outputs decode from the state flop alone, so reset drops PSEL/PENABLE immediately.
  always_comb begin
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    case (state_q)
      StRd1Setup, StRd1Access: begin
        PSEL    = 1'b1;
        PENABLE = (state_q == StRd1Access);
        PADDR   = addr_a_q;
      end
      StRd2Setup, StRd2Access: begin
        PSEL    = 1'b1;
        PENABLE = (state_q == StRd2Access);
        PADDR   = addr_b_q;
      end
      StWrSetup, StWrAccess: begin
        PSEL    = 1'b1;
        PENABLE = (state_q == StWrAccess);
        PWRITE  = 1'b1;
        PADDR   = waddr_q;
        PWDATA  = wdata;
      end
      default: ;
    endcase
  end

  assign busy              = (state_q != StIdle) && (state_q != StDone);
  assign operand1          = op1_q;
  assign operand2          = op2_q;
  assign result            = acc_q;
  assign reading_completed = rdc_q;
  assign write_completed   = wrc_q;
  assign error             = err_q;

endmodule

// File: tb/tb_apb_mac_master.sv
// Directed bench for apb_mac_master: an APB slave memory driven on the falling edge, plus a
// 16-bit instance for the accumulator-overflow case.
module tb_apb_mac_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        start;
  logic [7:0]  num_pairs;
  logic [31:0] Raddr1, Raddr2, Waddr;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [15:0] operand1, operand2;
  logic [39:0] result;
  logic        busy, reading_completed, write_completed, error;

  logic        start2;
  logic        psel2, penable2, pwrite2;
  logic [31:0] paddr2;
  logic [15:0] pwdata2, prdata2;
  logic [15:0] op1_2, op2_2;
  logic [39:0] result2;
  logic        busy2, rdc2, wrc2, err2;

  always #5 PCLK = ~PCLK;

  apb_mac_master u_dut (
    .PCLK(PCLK), .PRESET(PRESET), .start(start), .num_pairs(num_pairs),
    .Raddr1(Raddr1), .Raddr2(Raddr2), .Waddr(Waddr),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .operand1(operand1), .operand2(operand2), .result(result), .busy(busy),
    .reading_completed(reading_completed), .write_completed(write_completed), .error(error)
  );

  apb_mac_master #(.PDATA_W(16), .OP_W(16)) u_dut16 (
    .PCLK(PCLK), .PRESET(PRESET), .start(start2), .num_pairs(8'd2),
    .Raddr1(32'h0), .Raddr2(32'h100), .Waddr(32'h200),
    .PSEL(psel2), .PENABLE(penable2), .PWRITE(pwrite2), .PADDR(paddr2), .PWDATA(pwdata2),
    .PRDATA(prdata2), .PREADY(1'b1), .PSLVERR(1'b0),
    .operand1(op1_2), .operand2(op2_2), .result(result2), .busy(busy2),
    .reading_completed(rdc2), .write_completed(wrc2), .error(err2)
  );

  assign prdata2 = 16'hFFFF;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem [0:255];
  logic [31:0] log_addr [0:31];
  logic        log_wr [0:31];
  logic [31:0] log_wdata [0:31];
  int          nx, done_cyc, rc_cnt, wc_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One launch; slave answers with `waits` wait states on reads and PSLVERR on access err_at.
  task automatic run(input int n, input logic [31:0] ra1, input logic [31:0] ra2,
                     input logic [31:0] wa, input int waits, input int err_at, input bit poke);
    int wcnt = 0;
    bit fin = 0;
    logic [31:0] setup_addr = 32'h0;
    nx = 0; rc_cnt = 0; wc_cnt = 0; done_cyc = -1;
    @(negedge PCLK);
    start = 1'b1; num_pairs = n[7:0]; Raddr1 = ra1; Raddr2 = ra2; Waddr = wa;
    PREADY = 1'b0; PSLVERR = 1'b0;
    @(posedge PCLK);
    for (int k = 1; k <= 400 && !fin; k++) begin
      @(negedge PCLK);
      start = 1'b0;
      if (poke && k == 2) begin
        start = 1'b1; num_pairs = 8'd7;
      end
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
      if (reading_completed) rc_cnt++;
      if (write_completed) wc_cnt++;
      if (!busy) begin
        done_cyc = k; fin = 1;
        if (poke) start = 1'b1;
      end else if (PSEL && !PENABLE) begin
        setup_addr = PADDR;
      end else if (PSEL && PENABLE) begin
        if (!PWRITE && wcnt < waits) wcnt++;
        else begin
          wcnt = 0; PREADY = 1'b1; PRDATA = mem[PADDR[9:2]]; PSLVERR = (nx == err_at);
          check("paddr_stable", PADDR, setup_addr);
          if (nx < 32) begin
            log_addr[nx] = PADDR; log_wr[nx] = PWRITE; log_wdata[nx] = PWDATA;
          end
          nx++;
        end
      end
    end
    check("done_reached", fin, 1);
    @(negedge PCLK);
    start = 1'b0;
    if (poke) check("start_in_done_ignored", busy, 0);
  endtask

  initial begin
    logic [31:0] w2;
    bit          seen2;
    PRESET = 1'b1; start = 1'b0; start2 = 1'b0; num_pairs = 8'd0;
    Raddr1 = 32'h0; Raddr2 = 32'h0; Waddr = 32'h0;
    PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'd3; mem[8] = 32'd5;
    mem[16] = 32'd1;  mem[17] = 32'd2;  mem[18] = 32'd3;  mem[19] = 32'd4;
    mem[24] = 32'd10; mem[25] = 32'd20; mem[26] = 32'd30; mem[27] = 32'd40;

    #12;
    check("rst_psel", {PSEL, PENABLE, PWRITE}, 3'b000);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_status", {busy, reading_completed, write_completed, error}, 4'b0000);
    check("rst_result", result, 40'h0);
    check("rst_operands", {operand1, operand2}, 32'h0);
    @(negedge PCLK);
    PRESET = 1'b0;

    // N=1: 3*5 written to 0x80, DONE in cycle 7.
    run(1, 32'h10, 32'h20, 32'h80, 0, -1, 0);
    check("n1_done_cycle", done_cyc, 7);
    check("n1_xfers", nx, 3);
    check("n1_addr_a", log_addr[0], 32'h10);
    check("n1_addr_b", log_addr[1], 32'h20);
    check("n1_addr_w", log_addr[2], 32'h80);
    check("n1_dirs", {log_wr[0], log_wr[1], log_wr[2]}, 3'b001);
    check("n1_wdata", log_wdata[2], 32'd15);
    check("n1_result", result, 40'd15);
    check("n1_operands", {operand1, operand2}, {16'd3, 16'd5});
    check("n1_pulses", {rc_cnt[3:0], wc_cnt[3:0]}, 8'h11);
    check("n1_error", error, 0);

    // N=4 with a start while busy and a start in DONE, both ignored.
    run(4, 32'h40, 32'h60, 32'h84, 0, -1, 1);
    check("n4_done_cycle", done_cyc, 19);
    check("n4_xfers", nx, 9);
    for (int i = 0; i < 4; i++) begin
      check("n4_addr_a", log_addr[2*i], 32'h40 + 32'(4*i));
      check("n4_addr_b", log_addr[2*i+1], 32'h60 + 32'(4*i));
    end
    check("n4_addr_w", log_addr[8], 32'h84);
    check("n4_wdata", log_wdata[8], 32'd300);
    check("n4_result", result, 40'd300);

    // N=2 with 3 wait cycles on every read access.
    run(2, 32'h40, 32'h60, 32'h88, 3, -1, 0);
    check("wait_done_cycle", done_cyc, 23);
    check("wait_wdata", log_wdata[4], 32'd50);
    check("wait_result", result, 40'd50);

    // N=3, slave error on the third read (A of pair 1).
    run(3, 32'h40, 32'h60, 32'h8C, 0, 2, 0);
    check("err_flag", error, 1);
    check("err_xfers", nx, 3);
    check("err_done_cycle", done_cyc, 7);
    check("err_no_write_pulse", wc_cnt, 0);
    check("err_no_read_pulse", rc_cnt, 0);
    check("err_partial", result, 40'd10);

    // N=0 writes 0 directly and clears the sticky error.
    run(0, 32'h40, 32'h60, 32'h88, 0, -1, 0);
    check("n0_error_cleared", error, 0);
    check("n0_done_cycle", done_cyc, 3);
    check("n0_xfers", nx, 1);
    check("n0_addr", log_addr[0], 32'h88);
    check("n0_write", {log_wr[0], log_wdata[0]}, {1'b1, 32'h0});

    // Reset while stalled in the stream-B access.
    @(negedge PCLK);
    start = 1'b1; num_pairs = 8'd1; Raddr1 = 32'h10; Raddr2 = 32'h20; Waddr = 32'h80;
    PREADY = 1'b1; PRDATA = 32'd3;
    @(posedge PCLK);
    for (int k = 1; k <= 4; k++) begin
      @(negedge PCLK);
      start = 1'b0;
      PREADY = (k < 4);
    end
    check("rd2_access_bus", {PSEL, PENABLE, PWRITE}, 3'b110);
    check("rd2_access_addr", PADDR, 32'h20);
    #1 PRESET = 1'b1;
    #1;
    check("rst_mid_psel", {PSEL, PENABLE}, 2'b00);
    check("rst_mid_busy", busy, 0);
    @(negedge PCLK);
    PRESET = 1'b0; PREADY = 1'b0;
    run(0, 32'h0, 32'h0, 32'h90, 0, -1, 0);
    check("post_rst_addr", log_addr[0], 32'h90);
    check("post_rst_wdata", log_wdata[0], 32'h0);
    check("post_rst_done", done_cyc, 3);

    // 16-bit data path: two 0xFFFF*0xFFFF products overflow PDATA_W.
    w2 = 32'h0; seen2 = 0;
    @(negedge PCLK);
    start2 = 1'b1;
    @(negedge PCLK);
    start2 = 1'b0;
    for (int k = 0; k < 50 && !wrc2; k++) begin
      @(negedge PCLK);
      if (psel2 && penable2 && pwrite2) begin
        w2 = {16'h0, pwdata2}; seen2 = 1;
      end
    end
    check("w16_write_seen", seen2, 1);
    check("w16_write_pulse", wrc2, 1);
`ifdef APB_MAC_SAT_EN
    check("w16_wdata", w2, 32'h0000FFFF);
    check("w16_result", result2, 40'h00_0000_FFFF);
`else
    check("w16_wdata", w2, 32'h00000002);
    check("w16_result", result2, 40'h01_FFFC_0002);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
